// File: rtl/sqrt_sched_if.sv
// Request/response bundle between the QR column-norm engines and the shared
// square-root scheduler.
interface sqrt_sched_if #(
  parameter int N_REQ = 4,
  parameter int IN_W  = 56,
  parameter int OUT_W = IN_W / 2,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*IN_W-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [OUT_W-1:0]      rsp_data;
  logic                  rsp_ready;
  logic                  busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/sqrt_sched.sv
// Round-robin scheduler around one non-restoring integer square-root engine
// (one root bit per clock), returning results tagged with the requester index.
module sqrt_sched #(
  parameter int N_REQ = 4,
  parameter int IN_W  = 56,
  parameter int OUT_W = IN_W / 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic         clk,
  input  logic         rst_n,
  sqrt_sched_if.slave  bus
);
  localparam int R_W   = OUT_W + 2;
  localparam int CNT_W = $clog2(OUT_W);
  localparam int IDX_W = ID_W + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  a_q, a_d;
  logic [R_W-1:0]   r_q, r_d;
  logic [OUT_W-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [N_REQ-1:0] req_ready_d;

  logic [IN_W-1:0] radicand [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign radicand[gi] = bus.req_data[gi*IN_W +: IN_W];
    end
  endgenerate

  // Scan offsets from N_REQ down to 1 so the smallest offset past last_q wins.
  logic             grant_any;
  logic [ID_W-1:0]  winner;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = {1'b0, last_q} + IDX_W'(i);
      if (idx >= IDX_W'(N_REQ)) begin
        idx = idx - IDX_W'(N_REQ);
      end
      if (bus.req_valid[idx[ID_W-1:0]]) begin
        grant_any = 1'b1;
        winner    = idx[ID_W-1:0];
      end
    end
  end

  logic [R_W-1:0] left, right, r_new;

  assign left  = {r_q[OUT_W-1:0], a_q[IN_W-1 -: 2]};
  assign right = {q_q, r_q[R_W-1], 1'b1};
  assign r_new = r_q[R_W-1] ? (left + right) : (left - right);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    r_d         = r_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    last_d      = last_q;
    req_ready_d = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          req_ready_d[winner] = 1'b1;
          a_d     = radicand[winner];
          id_d    = winner;
          q_d     = '0;
          r_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = a_q << 2;
        r_d   = r_new;
        q_d   = {q_q[OUT_W-2:0], ~r_new[R_W-1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(OUT_W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Fairness pointer advances only once the result has left the block.
        if (bus.rsp_ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      last_q  <= ID_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign bus.req_ready = req_ready_d;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_data  = (state_q == DONE) ? q_q  : '0;
  assign bus.rsp_id    = (state_q == DONE) ? id_q : '0;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/sqrt_sched.md
# sqrt_sched

Shared-resource scheduler and sequencer for the integer square-root datapath in the 4x4 QR-based MIMO detector. Several QR column-norm engines each need floor(sqrt(x)) of a 56-bit squared norm. One non-restoring square-root engine is time-shared between them. The block arbitrates round-robin, runs the non-restoring recurrence one root bit per clock, and returns the result tagged with the requester index over a valid/ready response channel.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- IN_W, 56: radicand width; must be even.
- OUT_W, IN_W/2 (28): root width.
- ID_W, 2: requester tag width, equal to clog2(N_REQ).
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_data  in  N_REQ*IN_W  radicands; requester k occupies bits [k*IN_W +: IN_W].
- req_ready  out  N_REQ  one-hot grant; at most one bit high.
- rsp_valid  out  1  result available.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_data  out  OUT_W  floor(sqrt(radicand)).
- rsp_ready  in  1  consumer accepts the result.
- busy  out  1  high in CALC or DONE.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - If any req_valid is high, the arbiter picks the first set bit, searching from (last_grant+1) mod N_REQ upward with wrap-around.
  - req_ready[winner] is driven high combinationally in the same cycle.
  - On that edge the block latches a <= req_data[winner], id <= winner, q <= 0, r <= 0, cnt <= 0, and moves to CALC.
  - With no req_valid high, the block stays in IDLE and all req_ready are 0.
- **CALC**: one iteration per cycle, with r a 30-bit signed remainder, q a 28-bit root and a the shifting radicand.
  - left = {r[27:0], a[IN_W-1:IN_W-2]}.
  - right = {q, r[29], 1'b1}.
  - a <= a << 2.
  - r <= r[29] ? left + right : left - right, computed modulo 2^30.
  - q <= {q[26:0], ~r_new[29]}.
  - cnt increments each cycle. After the iteration with cnt = OUT_W-1, the block moves to DONE.
  - No remainder-correction step follows; the result is q only.
- **DONE**
  - rsp_valid = 1, rsp_data = q, rsp_id = id.
  - These outputs hold stable until rsp_ready is sampled high.
  - On the accept edge: last_grant <= id, then IDLE.
- last_grant updates only on response acceptance, never on the grant itself.
- req_ready is 0 in CALC and DONE. Requesters must hold req_valid and req_data until granted.
- Any requester whose req_valid drops before its grant is simply skipped; no error is raised.
- Reset values:
  - state = IDLE, last_grant = N_REQ-1, so requester 0 has first priority.
  - q = 0, r = 0, cnt = 0, id = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0, req_ready = 0.
- Reset mid-operation: the in-flight radicand and result are discarded. No response is issued for that request. The FSM returns to IDLE immediately (asynchronously).

## Timing
- Grant in cycle T: req_ready high during T, radicand captured at the end of T.
- CALC occupies cycles T+1 .. T+OUT_W (28 cycles).
- rsp_valid rises at the start of cycle T+OUT_W+1 (T+29).
- With rsp_ready held high:
  - the response is accepted in T+29 and the FSM is in IDLE at T+30;
  - the next grant can occur in T+30;
  - minimum issue period is 30 cycles per result.
- Backpressure: each cycle of rsp_ready = 0 in DONE adds one cycle. No new grant occurs until acceptance.
- Simultaneous requests: exactly one grant per IDLE cycle. The rest wait; their req_ready stays 0.
- busy is registered from state; it is high exactly when state is not IDLE.

## Test plan
- **Single request**
  - Stimulus: req_valid[0]=1, req_data=144, rsp_ready=1.
  - Response: req_ready[0] pulses one cycle; 29 cycles later rsp_valid=1, rsp_data=12, rsp_id=0.
- **Boundary values**
  - Stimulus: radicands 0, 1, 2, 3, 4, 2^56-1.
  - Response: 0, 1, 1, 1, 2, 268435455, each in 29 cycles after grant.
- **Round-robin**
  - Stimulus: all four req_valid held high after reset, rsp_ready=1.
  - Response: grants in order 0,1,2,3,0, exactly 30 cycles apart; each rsp_id matches its grant.
- **Backpressure**
  - Stimulus: rsp_ready=0 for 10 cycles after rsp_valid rises; requester 1 pending meanwhile.
  - Response: rsp_data/rsp_id stable for all 10 cycles; req_ready[1] stays 0 until the cycle after acceptance.
- **Reset mid-CALC**
  - Stimulus: assert rst_n=0 at cnt=14 without a clock edge, then release.
  - Response: rsp_valid=0 immediately, busy=0, no response is issued for that request; next grant goes to requester 0.
- **Random regression**
  - Stimulus: 10k random 56-bit radicands on random requesters with random rsp_ready.
  - Response: every rsp_data equals floor(sqrt(x)) from the model; rsp_id matches the issuing requester; no request is lost or duplicated.
